// File: rtl/gtp_arb_pkg.sv
// rtl/gtp_arb_pkg.sv - shared types for the gtpfifo block arbiter
package gtp_arb_pkg;

  localparam int NCH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CW   = 2'd1,
    ST_BODY = 2'd2
  } state_t;

  // Control word layout: len[8:1] is the number of dwords that follow the CW.
  typedef struct packed {
    logic [15:0] rsvd;
    logic        flag;
    logic [5:0]  chan;
    logic [8:0]  len;
  } cw_t;

endpackage

// File: rtl/gtp_arb_if.sv
// rtl/gtp_arb_if.sv - fifo-side and writer-side signals of the block arbiter
interface gtp_arb_if
  import gtp_arb_pkg::*;
#(
  parameter int NCH = NCH_DEFAULT
) ();

  logic [NCH-1:0]    req_empty;
  logic [NCH-1:0]    req_have;
  logic [32*NCH-1:0] req_data;
  logic [NCH-1:0]    req_give;
  logic [31:0]       dout;
  logic              dout_vld;
  logic              dout_sop;
  logic              dout_eop;
  logic              dout_rdy;

  modport master (
    input  req_empty, req_have, req_data, dout_rdy,
    output req_give, dout, dout_vld, dout_sop, dout_eop
  );

  modport slave (
    output req_empty, req_have, req_data, dout_rdy,
    input  req_give, dout, dout_vld, dout_sop, dout_eop
  );

endinterface

// File: rtl/gtp_arb_rr_pick.sv
// rtl/gtp_arb_rr_pick.sv - combinational round-robin priority encoder
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] grant,
  output logic         any
);

  localparam int W1 = W + 1;

  logic [W:0] s;

  // Walk offsets from farthest to nearest so the nearest request wins last.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    s     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      s = {1'b0, start} + W1'(k);
      if (s >= W1'(N)) s = s - W1'(N);
      if (req[s[W-1:0]]) begin
        grant = s[W-1:0];
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gtp_arb.sv
// rtl/gtp_arb.sv - round-robin block arbiter from gtpfifos toward the MIG writer
module gtp_arb
  import gtp_arb_pkg::*;
#(
  parameter int NCH    = NCH_DEFAULT,
  parameter int CW_TMO = 3
) (
  input  logic                    gtp_clk,
  input  logic                    rst,
  input  logic                    enable,
  gtp_arb_if.master               bus,
  output logic [$clog2(NCH)-1:0]  cur_ch,
  output logic                    busy,
  output logic [31:0]             blk_cnt,
  output logic                    err_cw,
  output logic                    err_undr
);

  localparam int CHW = $clog2(NCH);
  localparam int TW  = $clog2(CW_TMO + 1);

  state_t         state, state_nx;
  logic [CHW-1:0] rr_ptr, pick, nxt_ptr;
  logic           pick_any, give_on, have;
  logic [7:0]     remaining;
  logic [TW-1:0]  tmo;
  cw_t            word;
  logic           cw_ok, cw_bad, cw_tmo, body_take, body_undr, blk_last, blk_end;

  rr_pick #(.N(NCH)) u_pick (
    .req   (~bus.req_empty),
    .start (rr_ptr),
    .grant (pick),
    .any   (pick_any)
  );

  always_comb begin
    word = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cur_ch == CHW'(i)) word = bus.req_data[32*i +: 32];
    end
  end

  assign have      = give_on && bus.req_have[cur_ch];
  assign nxt_ptr   = (cur_ch == CHW'(NCH - 1)) ? '0 : cur_ch + 1'b1;
  assign cw_ok     = (state == ST_CW) && have && word.flag;
  assign cw_bad    = (state == ST_CW) && have && !word.flag;
  assign cw_tmo    = (state == ST_CW) && give_on && !have && (tmo == TW'(CW_TMO - 1));
  assign body_take = (state == ST_BODY) && have;
  assign body_undr = (state == ST_BODY) && give_on && !have;
  assign blk_last  = (cw_ok && (word.len[8:1] == 8'd0)) || (body_take && (remaining == 8'd1));
  assign blk_end   = blk_last || cw_bad || cw_tmo || body_undr;

  always_ff @(posedge gtp_clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // enable is only looked at in IDLE so a running block always completes.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (enable && pick_any) state_nx = ST_CW;
      ST_CW: begin
        if (cw_ok && !blk_last) state_nx = ST_BODY;
        else if (blk_end)       state_nx = ST_IDLE;
      end
      ST_BODY: if (blk_end) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // give is withheld while rst is high so the fifos never see a stray pop.
  always_comb begin
    give_on      = (state != ST_IDLE) && bus.dout_rdy && !rst;
    bus.req_give = give_on ? (NCH'(1) << cur_ch) : '0;
    busy         = (state != ST_IDLE);
  end

  always_ff @(posedge gtp_clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      cur_ch       <= '0;
      remaining    <= '0;
      tmo          <= '0;
      blk_cnt      <= '0;
      bus.dout     <= '0;
      bus.dout_vld <= 1'b0;
      bus.dout_sop <= 1'b0;
      bus.dout_eop <= 1'b0;
      err_cw       <= 1'b0;
      err_undr     <= 1'b0;
    end else begin
      bus.dout_vld <= 1'b0;
      bus.dout_sop <= 1'b0;
      bus.dout_eop <= 1'b0;
      err_cw       <= cw_bad;
      err_undr     <= body_undr;
      if ((state == ST_IDLE) && enable && pick_any) begin
        cur_ch <= pick;
        tmo    <= '0;
      end
      if (cw_ok || body_take) begin
        bus.dout     <= word;
        bus.dout_vld <= 1'b1;
        bus.dout_sop <= cw_ok;
        bus.dout_eop <= blk_last;
      end
      if (cw_ok)          remaining <= word.len[8:1];
      else if (body_take) remaining <= remaining - 8'd1;
      // Timeout only advances on cycles where a give was actually offered.
      if ((state == ST_CW) && give_on && !have) tmo <= cw_tmo ? '0 : tmo + 1'b1;
      if (blk_last) blk_cnt <= blk_cnt + 32'd1;
      if (blk_end)  rr_ptr  <= nxt_ptr;
    end
  end

endmodule

// File: tb/tb_gtp_arb.sv
// tb/tb_gtp_arb.sv - self-checking bench for gtp_arb against a block-level model
module tb_gtp_arb;
  import gtp_arb_pkg::*;

  localparam int NCH   = 4;
  localparam int DEPTH = 512;

  logic        gtp_clk = 1'b0;
  logic        rst     = 1'b1;
  logic        enable  = 1'b0;
  logic [1:0]  cur_ch;
  logic        busy;
  logic [31:0] blk_cnt;
  logic        err_cw, err_undr;

  gtp_arb_if #(.NCH(NCH)) bus ();

  gtp_arb #(.NCH(NCH), .CW_TMO(3)) dut (
    .gtp_clk  (gtp_clk),
    .rst      (rst),
    .enable   (enable),
    .bus      (bus.master),
    .cur_ch   (cur_ch),
    .busy     (busy),
    .blk_cnt  (blk_cnt),
    .err_cw   (err_cw),
    .err_undr (err_undr)
  );

  always #5 gtp_clk = ~gtp_clk;

  // fifo models: have answers give in the same cycle while data is present
  logic [31:0] fmem [NCH][DEPTH];
  int          wr [NCH] = '{0, 0, 0, 0};
  int          rd [NCH] = '{0, 0, 0, 0};
  logic        stall [NCH] = '{1'b0, 1'b0, 1'b0, 1'b0};

  always_comb begin
    bus.req_empty = '0;
    bus.req_have  = '0;
    bus.req_data  = '0;
    for (int i = 0; i < NCH; i++) begin
      bus.req_empty[i]         = (rd[i] == wr[i]);
      bus.req_have[i]          = bus.req_give[i] && !stall[i] && (rd[i] != wr[i]);
      bus.req_data[32*i +: 32] = fmem[i][rd[i] % DEPTH];
    end
  end

  always @(posedge gtp_clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst)                  rd[i] <= wr[i];
      else if (bus.req_have[i]) rd[i] <= rd[i] + 1;
    end
  end

  // monitor
  logic [33:0] obs [$];
  int ecw_n = 0, eu_n = 0, viol_n = 0, g3_n = 0;

  always @(negedge gtp_clk) begin
    if (bus.dout_vld) obs.push_back({bus.dout_sop, bus.dout_eop, bus.dout});
    if (err_cw)   ecw_n  <= ecw_n + 1;
    if (err_undr) eu_n   <= eu_n + 1;
    if (!bus.dout_rdy && (bus.req_give != '0)) viol_n <= viol_n + 1;
    if ($countones(bus.req_give) > 1)          viol_n <= viol_n + 1;
    if (bus.req_give[3]) g3_n <= g3_n + 1;
  end

  // block-level reference model
  logic [31:0] mq [NCH][$];
  logic [33:0] exp_q [$];
  int m_rr = 0, m_blk = 0, m_ecw = 0, m_eu = 0;
  int obs_base = 0, ecw_base = 0, eu_base = 0;
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic push(input int ch, input logic [31:0] w, input bit to_model);
    fmem[ch][wr[ch] % DEPTH] = w;
    wr[ch] = wr[ch] + 1;
    if (to_model) mq[ch].push_back(w);
  endtask

  task automatic push_blk(input int ch, input int n, input int nbody, input bit to_model);
    logic [31:0] r;
    r = $urandom;
    push(ch, {r[31:16], 1'b1, 6'(ch), 8'(n), r[0]}, to_model);
    for (int k = 0; k < nbody; k++) push(ch, $urandom, to_model);
  endtask

  task automatic model_run();
    int ch, n;
    bit done;
    logic [31:0] w, d;
    while (1) begin
      ch = -1;
      for (int k = 0; k < NCH; k++)
        if (ch < 0 && mq[(m_rr + k) % NCH].size() > 0) ch = (m_rr + k) % NCH;
      if (ch < 0) break;
      w = mq[ch].pop_front();
      if (!w[15]) begin
        m_ecw++;
      end else begin
        n    = int'(w[8:1]);
        done = (n == 0);
        exp_q.push_back({1'b1, done, w});
        for (int k = 1; k <= n; k++) begin
          if (mq[ch].size() == 0) begin
            m_eu++;
            break;
          end
          d = mq[ch].pop_front();
          exp_q.push_back({1'b0, k == n, d});
          if (k == n) done = 1'b1;
        end
        if (done) m_blk++;
      end
      m_rr = (ch + 1) % NCH;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) mq[i].delete();
    exp_q.delete();
    m_rr = 0; m_blk = 0; m_ecw = 0; m_eu = 0;
  endtask

  task automatic sync_base();
    obs_base = obs.size();
    ecw_base = ecw_n;
    eu_base  = eu_n;
  endtask

  task automatic compare(input string tag);
    int nob;
    nob = obs.size() - obs_base;
    chk({tag, " words"}, nob, exp_q.size());
    for (int k = 0; k < nob && k < exp_q.size(); k++)
      chk({tag, " word"}, obs[obs_base + k], exp_q[k]);
    chk({tag, " err_cw"}, ecw_n - ecw_base, m_ecw);
    chk({tag, " err_undr"}, eu_n - eu_base, m_eu);
    chk({tag, " blk_cnt"}, blk_cnt, m_blk);
    chk({tag, " give_rule"}, viol_n, 0);
    m_ecw = 0; m_eu = 0;
    exp_q.delete();
    sync_base();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NCH; i++) if (rd[i] != wr[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_idle(input string tag, input int mode, input int budget);
    int quiet, cyc;
    quiet = 0; cyc = 0;
    while (quiet < 4 && cyc < budget) begin
      @(posedge gtp_clk); #1;
      case (mode)
        1:       bus.dout_rdy = ~bus.dout_rdy;
        2:       bus.dout_rdy = ($urandom_range(0, 3) != 0);
        default: bus.dout_rdy = 1'b1;
      endcase
      if (!busy && all_empty()) quiet++; else quiet = 0;
      cyc++;
    end
    bus.dout_rdy = 1'b1;
    chk({tag, " drained"}, quiet >= 4, 1);
    repeat (2) @(posedge gtp_clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge gtp_clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge gtp_clk);
    #1;
    rst = 1'b0;
    model_clear();
    @(negedge gtp_clk);
    sync_base();
    @(posedge gtp_clk); #1;
  endtask

  task automatic wait_words(input string tag, input int nw, input int budget);
    int cyc;
    cyc = 0;
    while ((obs.size() - obs_base) < nw && cyc < budget) begin
      @(posedge gtp_clk); #1;
      cyc++;
    end
    chk({tag, " reached"}, (obs.size() - obs_base) >= nw, 1);
  endtask

  initial begin
    int g3b, cyc, nb, n, nbody;
    logic [31:0] r;
    bus.dout_rdy = 1'b1;

    // reset values
    repeat (3) @(posedge gtp_clk);
    #1;
    chk("rst dout", bus.dout, 0);
    chk("rst dout_vld", {bus.dout_vld, bus.dout_sop, bus.dout_eop}, 0);
    chk("rst give", bus.req_give, 0);
    chk("rst busy", busy, 0);
    chk("rst cur_ch", cur_ch, 0);
    chk("rst blk_cnt", blk_cnt, 0);
    chk("rst err", {err_cw, err_undr}, 0);
    rst = 1'b0;
    @(negedge gtp_clk);
    sync_base();

    // CW 0x8205 in fifo 1: three words
    push(1, 32'h0000_8205, 1'b1);
    push(1, 32'hA5A5_0001, 1'b1);
    push(1, 32'hA5A5_0002, 1'b1);
    model_run();
    enable = 1'b1;
    cyc = 0;
    while (!busy && cyc < 10) begin @(posedge gtp_clk); #1; cyc++; end
    chk("blk1 cur_ch", cur_ch, 1);
    run_idle("blk1", 0, 200);
    compare("blk1");

    // fifos 0 and 2 from rr_ptr 0
    do_reset();
    enable = 1'b0;
    push_blk(0, 1, 1, 1'b1);
    push_blk(2, 1, 1, 1'b1);
    model_run();
    enable = 1'b1;
    run_idle("rr02", 0, 200);
    compare("rr02");

    // 10-dword block with dout_rdy toggling every cycle
    enable = 1'b0;
    push_blk(1, 9, 9, 1'b1);
    model_run();
    enable = 1'b1;
    run_idle("toggle", 1, 400);
    compare("toggle");

    // enable dropped mid-block
    enable = 1'b0;
    push_blk(2, 7, 7, 1'b1);
    model_run();
    enable = 1'b1;
    wait_words("endrop", 2, 50);
    enable = 1'b0;
    run_idle("endrop", 0, 200);
    compare("endrop");

    // rr_ptr is 3 now: fifo 3 never answers, fifo 0 must follow its timeout
    stall[3] = 1'b1;
    push_blk(3, 2, 2, 1'b0);
    push_blk(0, 2, 2, 1'b1);
    model_run();
    g3b = g3_n;
    enable = 1'b1;
    wait_words("stall", 3, 80);
    chk("stall give cycles", g3_n - g3b, 3);
    enable = 1'b0;
    cyc = 0;
    while (busy && cyc < 20) begin @(posedge gtp_clk); #1; cyc++; end
    chk("stall idle", busy, 0);
    repeat (3) @(posedge gtp_clk);
    #1;
    compare("stall");
    do_reset();
    stall[3] = 1'b0;

    // bad control word, then body underrun
    push(1, 32'h0000_1234, 1'b1);
    model_run();
    enable = 1'b1;
    run_idle("badcw", 0, 100);
    compare("badcw");
    enable = 1'b0;
    push_blk(2, 4, 2, 1'b1);
    model_run();
    enable = 1'b1;
    run_idle("undr", 0, 100);
    compare("undr");

    // longest block: CW + 255 under random backpressure
    enable = 1'b0;
    push_blk(0, 255, 255, 1'b1);
    model_run();
    enable = 1'b1;
    run_idle("maxblk", 2, 3000);
    compare("maxblk");

    // random mixes of blocks across fifos
    for (int round = 0; round < 6; round++) begin
      enable = 1'b0;
      for (int ch = 0; ch < NCH; ch++) begin
        nb = $urandom_range(0, 2);
        for (int b = 0; b < nb; b++) begin
          if ($urandom_range(0, 7) == 0) begin
            r = $urandom;
            r[15] = 1'b0;
            push(ch, r, 1'b1);
          end else begin
            n = $urandom_range(0, 12);
            nbody = n;
            if (b == nb - 1 && $urandom_range(0, 5) == 0) nbody = $urandom_range(0, n);
            push_blk(ch, n, nbody, 1'b1);
          end
        end
      end
      model_run();
      enable = 1'b1;
      run_idle("rand", (round % 2 == 0) ? 2 : 1, 2000);
      compare("rand");
    end

    // reset in the middle of a block
    enable = 1'b0;
    push_blk(1, 19, 19, 1'b1);
    enable = 1'b1;
    wait_words("rstmid", 3, 50);
    rst = 1'b1;
    #1;
    chk("rstmid give", bus.req_give, 0);
    @(posedge gtp_clk); #1;
    chk("rstmid dout", bus.dout, 0);
    chk("rstmid vld", {bus.dout_vld, bus.dout_sop, bus.dout_eop}, 0);
    chk("rstmid busy", busy, 0);
    chk("rstmid cur_ch", cur_ch, 0);
    chk("rstmid blk_cnt", blk_cnt, 0);
    chk("rstmid err", {err_cw, err_undr}, 0);
    rst = 1'b0;
    model_clear();
    @(negedge gtp_clk);
    sync_base();
    run_idle("after rst", 0, 50);
    compare("after rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gtp_arb.md
GTP_ARB -- requirements
Module: gtp_arb

Interface
REQ-001 Parameter NCH, default 4, number of gtpfifo requesters (2..16).
REQ-002 Parameter CW_TMO, default 3, idle cycles without have before a requester is skipped.
REQ-003 gtp_clk  in  1  clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 enable  in  1  arbitration enable; 0 = finish current block, then stay IDLE.
REQ-006 req_empty  in  NCH  per-fifo empty flag (read pointer == write pointer).
REQ-007 req_have  in  NCH  per-fifo have; data valid and read pointer advanced in the same cycle.
REQ-008 req_data  in  32*NCH  per-fifo read data; slice i = bits [32i+31:32i].
REQ-009 req_give  out  NCH  per-fifo give strobe; at most one bit set.
REQ-010 dout  out  32  registered block word toward the MIG writer.
REQ-011 dout_vld  out  1  dout valid for exactly one cycle per word.
REQ-012 dout_sop / dout_eop  out  1 each  first / last word of a block, aligned with dout_vld.
REQ-013 dout_rdy  in  1  downstream can take at least 2 more words.
REQ-014 cur_ch  out  clog2(NCH)  index of the requester being served.
REQ-015 busy  out  1  high in CW or BODY state.
REQ-016 blk_cnt  out  32  count of completed blocks, wraps at 2^32.
REQ-017 err_cw / err_undr  out  1 each  single-cycle error pulses.

Function
REQ-018 States: IDLE, CW, BODY; enumerated in package.
REQ-019 IDLE: if enable, select first i with req_empty[i]=0, searching round-robin from rr_ptr; set cur_ch = i; go to CW next cycle; if none, stay IDLE.
REQ-020 CW: assert req_give[cur_ch] only while dout_rdy=1; with no dout_rdy, hold and do not count timeout.
REQ-021 CW with have: capture word; if bit15 of word is 1, set remaining = word[8:1] (dwords after CW), emit word with sop=1; if remaining==0, set eop=1, go IDLE; else go BODY.
REQ-022 CW with have and bit15=0: emit nothing, pulse err_cw, go IDLE, rr_ptr = cur_ch+1.
REQ-023 CW timeout: after CW_TMO consecutive give cycles without have (partial block only), go IDLE, rr_ptr = cur_ch+1; no error.
REQ-024 BODY: assert give only while dout_rdy=1; each have emits word and decrements remaining; the word taken when remaining==1 carries eop=1, then go IDLE.
REQ-025 BODY give without have: pulse err_undr, emit eop-less truncation (no word), go IDLE, rr_ptr = cur_ch+1.
REQ-026 On block completion: blk_cnt += 1 in the eop cycle, rr_ptr = cur_ch+1 modulo NCH.
REQ-027 Latency: dout/dout_vld registered, one cycle after the have cycle; throughput one dword per cycle while dout_rdy=1.
REQ-028 Downstream shall accept any word with dout_vld=1 regardless of dout_rdy (one-word slack).
REQ-029 req_give is combinational from state, cur_ch and dout_rdy; no give in IDLE.
REQ-030 enable falling mid-block shall not truncate the block.
REQ-031 Remaining counter 8 bits; maximum block 256 dwords (CW + 255).

Reset
REQ-032 rst sets state IDLE, rr_ptr 0, cur_ch 0, remaining 0, timeout 0, blk_cnt 0, dout 0, dout_vld/sop/eop 0, err pulses 0; req_give all 0 in the same cycle as rst.
REQ-033 rst mid-block abandons the block without error; the fifos are reset by the same rst.

Structure
REQ-034 Package gtp_arb_pkg: state enum, CW field positions (bit15 flag, [14:9] channel, [8:0] length), NCH default.
REQ-035 Sub-module rr_pick: combinational round-robin priority encoder (request vector, start pointer -> grant index, any).

Verification
REQ-036 Fifo 1 holds CW 0x8205 (len 5, 3 dwords): -> 3 dout words, sop on word 0, eop on word 2, blk_cnt 0->1, cur_ch=1.
REQ-037 Fifos 0 and 2 each hold one 2-dword block, rr_ptr=0: -> fifo 0 block served, then fifo 2, no gap words interleaved.
REQ-038 dout_rdy toggles 1/0 every cycle during a 10-dword block: -> 10 words, order preserved, no give while dout_rdy=0.
REQ-039 Fifo 3 non-empty but have never asserted: -> 3 give cycles, return IDLE, no dout, no error, fifo 0 served next if pending.
REQ-040 First dword 0x00001234 (bit15=0): -> err_cw 1 cycle, no dout; have dropped mid-body: -> err_undr 1 cycle, IDLE; rst mid-block: -> all outputs 0 next cycle.
